ss_map_table: RTL

- Superscalar register rename map table (speculative RAT), fed each cycle by the free list's free_reg outputs during dispatch.
- Translates source and destination architectural registers to physical registers, returns the previous mapping (pregold) to the ROB, and tracks physical-register ready bits from the CDB.
- Keeps an internal architectural (retirement) map, updated on retire, which restores the speculative map on rollback.

---
 rtl/rename_pkg.sv | 20 ++
 rtl/ss_map_table_if.sv | 34 +++
 rtl/ss_arch_map.sv | 36 +++
 rtl/ss_map_table.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename sizing, register index types and lookup result struct
package rename_pkg;

    localparam int WIDTH     = 2;
    localparam int ARCH_REGS = 32;
    localparam int PRF_SIZE  = 64;
    localparam int AREG_W    = $clog2(ARCH_REGS);
    localparam int PREG_W    = $clog2(PRF_SIZE);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    localparam preg_t ZERO_PREG = '0;

    typedef struct packed {
        preg_t preg;
        logic  ready;
    } lookup_t;

endpackage

// File: rtl/ss_map_table_if.sv
// rtl/ss_map_table_if.sv - dispatch/CDB/retire/rollback bundle of the rename map table
interface ss_map_table_if;
    import rename_pkg::*;

    logic  [WIDTH-1:0] dispatch_en;
    areg_t [WIDTH-1:0] dest_areg;
    areg_t [WIDTH-1:0] src1_areg;
    areg_t [WIDTH-1:0] src2_areg;
    preg_t [WIDTH-1:0] free_reg;
    preg_t [WIDTH-1:0] src1_preg;
    preg_t [WIDTH-1:0] src2_preg;
    logic  [WIDTH-1:0] src1_ready;
    logic  [WIDTH-1:0] src2_ready;
    preg_t [WIDTH-1:0] pregold;
    logic  [WIDTH-1:0] cdb_valid;
    preg_t [WIDTH-1:0] cdb_preg;
    logic  [WIDTH-1:0] retire_en;
    areg_t [WIDTH-1:0] retire_areg;
    preg_t [WIDTH-1:0] retire_preg;
    logic              rollback_en;

    modport master (
        output dispatch_en, dest_areg, src1_areg, src2_areg, free_reg,
        output cdb_valid, cdb_preg, retire_en, retire_areg, retire_preg, rollback_en,
        input  src1_preg, src2_preg, src1_ready, src2_ready, pregold
    );

    modport slave (
        input  dispatch_en, dest_areg, src1_areg, src2_areg, free_reg,
        input  cdb_valid, cdb_preg, retire_en, retire_areg, retire_preg, rollback_en,
        output src1_preg, src2_preg, src1_ready, src2_ready, pregold
    );

endinterface

// File: rtl/ss_arch_map.sv
// rtl/ss_arch_map.sv - committed (retirement) areg->preg map, exposes the post-retire image
module ss_arch_map
    import rename_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic  [WIDTH-1:0]     retire_en,
    input  areg_t [WIDTH-1:0]     retire_areg,
    input  preg_t [WIDTH-1:0]     retire_preg,
    output preg_t [ARCH_REGS-1:0] map_next
);

    preg_t [ARCH_REGS-1:0] map_q;

    // Apply this cycle's retires in lane order so lane 1 wins on a shared areg; areg 0 stays pinned
    always_comb begin
        map_next = map_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (retire_en[i] && retire_areg[i] != '0) begin
                map_next[retire_areg[i]] = retire_preg[i];
            end
        end
    end

    // Committed map register, identity after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                map_q[a] <= preg_t'(a);
            end
        end else begin
            map_q <= map_next;
        end
    end

endmodule

// File: rtl/ss_map_table.sv
// rtl/ss_map_table.sv - superscalar speculative rename map with ready bits and rollback
module ss_map_table
    import rename_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    ss_map_table_if.slave bus
);

    preg_t [ARCH_REGS-1:0] spec_map;
    logic  [PRF_SIZE-1:0]  ready;
    preg_t [ARCH_REGS-1:0] arch_next;
    logic                  lane0_writes;
    logic                  cdb_alloc_clash;

    ss_arch_map u_arch_map (
        .clock       (clock),
        .reset       (reset),
        .retire_en   (bus.retire_en),
        .retire_areg (bus.retire_areg),
        .retire_preg (bus.retire_preg),
        .map_next    (arch_next)
    );

    function automatic logic cdb_hit(preg_t p, logic [WIDTH-1:0] v, preg_t [WIDTH-1:0] cp);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (v[j] && cp[j] == p) hit = 1'b1;
        end
        return hit;
    endfunction

    // Areg 0 is hardwired; an older same-group writer overrides the map and is never ready yet
    function automatic lookup_t src_lookup(areg_t a, logic bypass, preg_t bypass_preg,
                                           preg_t mapped, logic mapped_ready);
        lookup_t r;
        if (a == '0) begin
            r.preg  = ZERO_PREG;
            r.ready = 1'b1;
        end else if (bypass) begin
            r.preg  = bypass_preg;
            r.ready = 1'b0;
        end else begin
            r.preg  = mapped;
            r.ready = mapped_ready;
        end
        return r;
    endfunction

    assign lane0_writes = bus.dispatch_en[0] && bus.dest_areg[0] != '0;

    // Per-lane source renaming and previous-mapping lookup; idle lanes drive zero
    always_comb begin
        bus.src1_preg  = '0;
        bus.src2_preg  = '0;
        bus.src1_ready = '0;
        bus.src2_ready = '0;
        bus.pregold    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lookup_t s1;
            lookup_t s2;
            s1 = src_lookup(bus.src1_areg[i],
                            (i == 1) && lane0_writes && bus.src1_areg[i] == bus.dest_areg[0],
                            bus.free_reg[0], spec_map[bus.src1_areg[i]],
                            ready[spec_map[bus.src1_areg[i]]] |
                            cdb_hit(spec_map[bus.src1_areg[i]], bus.cdb_valid, bus.cdb_preg));
            s2 = src_lookup(bus.src2_areg[i],
                            (i == 1) && lane0_writes && bus.src2_areg[i] == bus.dest_areg[0],
                            bus.free_reg[0], spec_map[bus.src2_areg[i]],
                            ready[spec_map[bus.src2_areg[i]]] |
                            cdb_hit(spec_map[bus.src2_areg[i]], bus.cdb_valid, bus.cdb_preg));
            if (bus.dispatch_en[i]) begin
                bus.src1_preg[i]  = s1.preg;
                bus.src1_ready[i] = s1.ready;
                bus.src2_preg[i]  = s2.preg;
                bus.src2_ready[i] = s2.ready;
                if (bus.dest_areg[i] == '0) begin
                    bus.pregold[i] = ZERO_PREG;
                end else if (i == 1 && bus.dispatch_en[0] && bus.dest_areg[1] == bus.dest_areg[0]) begin
                    bus.pregold[i] = bus.free_reg[0];
                end else begin
                    bus.pregold[i] = spec_map[bus.dest_areg[i]];
                end
            end
        end
    end

    // Speculative map and ready bits: rollback restores the committed image, else CDB sets then dispatch clears
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                spec_map[a] <= preg_t'(a);
            end
            ready <= '1;
        end else if (bus.rollback_en) begin
            spec_map <= arch_next;
            ready    <= '1;
        end else begin
            for (int j = 0; j < WIDTH; j++) begin
                if (bus.cdb_valid[j] && bus.cdb_preg[j] != ZERO_PREG) begin
                    ready[bus.cdb_preg[j]] <= 1'b1;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.dispatch_en[i] && bus.dest_areg[i] != '0) begin
                    spec_map[bus.dest_areg[i]] <= bus.free_reg[i];
                    ready[bus.free_reg[i]]     <= 1'b0;
                end
            end
        end
    end

    // A completion for a preg being allocated this very cycle means the free list handed out a live preg
    always_comb begin
        cdb_alloc_clash = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.cdb_valid[j] && bus.cdb_preg[j] != ZERO_PREG &&
                    bus.dispatch_en[i] && bus.dest_areg[i] != '0 &&
                    bus.cdb_preg[j] == bus.free_reg[i]) begin
                    cdb_alloc_clash = 1'b1;
                end
            end
        end
    end

    a_no_cdb_alloc_clash: assert property (@(posedge clock) disable iff (reset) !cdb_alloc_clash);

endmodule
